// File: rtl/multdiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit and the decode/hazard logic.
package multdiv_pkg;

  localparam int WIDTH = 32;
  localparam int CNT_W = 6;
  localparam int ITER  = WIDTH;

  localparam logic [4:0] ALUOP_MULT = 5'd6;
  localparam logic [4:0] ALUOP_DIV  = 5'd7;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

endpackage

// File: rtl/nrdiv_step.sv
// One iteration of non-restoring division on unsigned magnitudes.
module nrdiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH:0]   remNext,
  output logic [WIDTH-1:0] quoNext
);

  logic [WIDTH:0] shifted;

  // Partial remainder stays within +-divisor, so its low WIDTH bits carry the sign.
  always_comb begin
    shifted = {rem[WIDTH-1:0], quo[WIDTH-1]};
    if (rem[WIDTH]) remNext = shifted + {1'b0, dvs};
    else            remNext = shifted - {1'b0, dvs};
    quoNext = {quo[WIDTH-2:0], ~remNext[WIDTH]};
  end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed multiplier (radix-2 Booth) / divider (non-restoring) for the execute stage.
module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = multdiv_pkg::WIDTH,
  parameter int CNT_W = multdiv_pkg::CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state, stateN;
  logic [CNT_W-1:0] count, countN;
  logic [WIDTH:0]   hi, hiN;
  logic [WIDTH-1:0] lo, loN, opReg, opRegN;
  logic             qm1, qm1N, negQ, negQN, divZero, divZeroN, divOvf, divOvfN;
  logic [WIDTH-1:0] resultN;
  logic             excN, rdyN;

  logic [WIDTH:0]   mExt, boothSum, remStep;
  logic [WIDTH-1:0] quoStep, absA, absB;
  logic             mulOvf;

  nrdiv_step #(.WIDTH(WIDTH)) u_step (
    .rem    (hi),
    .quo    (lo),
    .dvs    (opReg),
    .remNext(remStep),
    .quoNext(quoStep)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      count          <= '0;
      hi             <= '0;
      lo             <= '0;
      opReg          <= '0;
      qm1            <= 1'b0;
      negQ           <= 1'b0;
      divZero        <= 1'b0;
      divOvf         <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      state          <= stateN;
      count          <= countN;
      hi             <= hiN;
      lo             <= loN;
      opReg          <= opRegN;
      qm1            <= qm1N;
      negQ           <= negQN;
      divZero        <= divZeroN;
      divOvf         <= divOvfN;
      data_result    <= resultN;
      data_exception <= excN;
      data_resultRDY <= rdyN;
    end
  end

  always_comb begin
    stateN   = state;
    countN   = count;
    hiN      = hi;
    loN      = lo;
    opRegN   = opReg;
    qm1N     = qm1;
    negQN    = negQ;
    divZeroN = divZero;
    divOvfN  = divOvf;
    resultN  = data_result;
    excN     = data_exception;
    rdyN     = 1'b0;

    // hi is one bit wider than the operand so subtracting the most negative multiplicand cannot wrap.
    mExt = {opReg[WIDTH-1], opReg};
    case ({lo[0], qm1})
      2'b01:   boothSum = hi + mExt;
      2'b10:   boothSum = hi - mExt;
      default: boothSum = hi;
    endcase
    mulOvf = (hi[WIDTH-1:0] != {WIDTH{lo[WIDTH-1]}});

    absA = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    absB = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    if (ctrl_MULT) begin
      stateN = MUL;
      countN = '0;
      hiN    = '0;
      loN    = data_operandB;
      opRegN = data_operandA;
      qm1N   = 1'b0;
    end else if (ctrl_DIV) begin
      stateN   = DIV;
      countN   = '0;
      hiN      = '0;
      loN      = absA;
      opRegN   = absB;
      negQN    = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      divZeroN = (data_operandB == '0);
      divOvfN  = (data_operandA == MIN_VAL) && (data_operandB == '1);
    end else begin
      case (state)
        MUL: begin
          if (count == CNT_W'(WIDTH)) begin
            resultN = lo;
            excN    = mulOvf;
            rdyN    = 1'b1;
            stateN  = DONE;
          end else begin
            hiN    = {boothSum[WIDTH], boothSum[WIDTH:1]};
            loN    = {boothSum[0], lo[WIDTH-1:1]};
            qm1N   = lo[0];
            countN = count + CNT_W'(1);
          end
        end
        DIV: begin
          if (divZero) begin
            resultN = '0;
            excN    = 1'b1;
            rdyN    = 1'b1;
            stateN  = DONE;
          end else if (count == CNT_W'(WIDTH)) begin
            resultN = negQ ? -lo : lo;
            excN    = divOvf;
            rdyN    = 1'b1;
            stateN  = DONE;
          end else begin
            hiN    = remStep;
            loN    = quoStep;
            countN = count + CNT_W'(1);
          end
        end
        DONE:    stateN = IDLE;
        default: stateN = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit against a plain-arithmetic reference model.
module tb_multdiv_unit;

  logic        clock;
  logic        reset;
  logic [31:0] opA, opB;
  logic        ctrlMULT, ctrlDIV;
  logic [31:0] result;
  logic        exception, resultRDY;

  int vectors = 0;
  int miscompares = 0;

  multdiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clock         (clock),
    .reset         (reset),
    .data_operandA (opA),
    .data_operandB (opB),
    .ctrl_MULT     (ctrlMULT),
    .ctrl_DIV      (ctrlDIV),
    .data_result   (result),
    .data_exception(exception),
    .data_resultRDY(resultRDY)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic void model(input bit isMul, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    longint p;
    if (isMul) begin
      p = longint'($signed(a)) * longint'($signed(b));
      r = p[31:0];
      e = (p != longint'($signed(p[31:0])));
    end else if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      r = $signed(a) / $signed(b);
      e = 1'b0;
    end
  endfunction

  // Caller is 1 time unit after a rising edge; returns edges from start edge to RDY (-1 on timeout).
  task automatic runOp(input logic mul, input logic dv, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] res, output logic exc, output logic held);
    logic [31:0] r0;
    logic        e0;
    r0 = result;
    e0 = exception;
    held = 1'b1;
    ctrlMULT = mul;
    ctrlDIV  = dv;
    opA = a;
    opB = b;
    @(posedge clock); #1;
    ctrlMULT = 1'b0;
    ctrlDIV  = 1'b0;
    opA = $urandom;
    opB = $urandom;
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clock); #1;
      if (resultRDY) begin
        lat = i;
        break;
      end
      if (result !== r0 || exception !== e0) held = 1'b0;
    end
    res = result;
    exc = exception;
  endtask

  task automatic checkOp(input string name, input logic mul, input logic dv,
                         input logic [31:0] a, input logic [31:0] b);
    int          lat, expLat;
    logic [31:0] res, expRes;
    logic        exc, expExc, held;
    model(mul, a, b, expRes, expExc);
    expLat = (!mul && b == 32'd0) ? 1 : 33;
    runOp(mul, dv, a, b, lat, res, exc, held);
    vectors++;
    if (lat !== expLat) begin
      miscompares++;
      $display("FAIL %s latency a=%h b=%h got %0d expected %0d", name, a, b, lat, expLat);
    end
    vectors++;
    if (res !== expRes) begin
      miscompares++;
      $display("FAIL %s result a=%h b=%h got %h expected %h", name, a, b, res, expRes);
    end
    vectors++;
    if (exc !== expExc) begin
      miscompares++;
      $display("FAIL %s exception a=%h b=%h got %b expected %b", name, a, b, exc, expExc);
    end
    vectors++;
    if (held !== 1'b1) begin
      miscompares++;
      $display("FAIL %s outputs_held_while_busy got %b expected 1", name, held);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    ctrlMULT = 1'b0;
    ctrlDIV  = 1'b0;
    opA = '0;
    opB = '0;
    repeat (3) @(posedge clock);
    #1;
    vectors++;
    if (result !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_result got %h expected 00000000", result);
    end
    vectors++;
    if (exception !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_exception got %b expected 0", exception);
    end
    vectors++;
    if (resultRDY !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_rdy got %b expected 0", resultRDY);
    end
    reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_mult;
    checkOp("mult_7x-6", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA);
    for (int i = 1; i <= 5; i++) begin
      @(posedge clock); #1;
      vectors++;
      if (resultRDY !== 1'b0 || result !== 32'hFFFF_FFD6 || exception !== 1'b0) begin
        miscompares++;
        $display("FAIL mult_hold cycle %0d got rdy=%b res=%h exc=%b expected 0 ffffffd6 0",
                 i, resultRDY, result, exception);
      end
    end
    checkOp("mult_ovf", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
    checkOp("mult_max", 1'b1, 1'b0, 32'h7FFF_FFFF, 32'd1);
    checkOp("mult_minxmin", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);
  endtask

  task automatic test_div;
    checkOp("div_-7/2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
    checkOp("div_100/-7", 1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9);
    checkOp("div_min/-1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    checkOp("div_5/0", 1'b0, 1'b1, 32'd5, 32'd0);
    checkOp("div_min/3", 1'b0, 1'b1, 32'h8000_0000, 32'd3);
  endtask

  task automatic test_random;
    logic        mul, dv;
    logic [31:0] a, b;
    int          sel;
    for (int n = 0; n < 40; n++) begin
      mul = 1'($urandom_range(0, 1));
      dv  = ~mul;
      a = $urandom;
      b = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 32'd0;
      if (sel == 1) b = 32'($urandom_range(0, 15)) - 32'd8;
      if (sel == 2 && !mul) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      if (sel == 3) a = 32'($urandom_range(0, 2000)) - 32'd1000;
      if (sel == 4 && mul) dv = 1'b1;
      checkOp("random", mul, dv, a, b);
    end
  endtask

  task automatic test_abort;
    logic [31:0] r0;
    logic        e0, sawRdy, held;
    r0 = result;
    e0 = exception;
    sawRdy = 1'b0;
    held = 1'b1;
    ctrlMULT = 1'b1;
    opA = 32'd3;
    opB = 32'd4;
    @(posedge clock); #1;
    ctrlMULT = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clock); #1;
      if (resultRDY) sawRdy = 1'b1;
      if (result !== r0 || exception !== e0) held = 1'b0;
    end
    vectors++;
    if (sawRdy !== 1'b0 || held !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_busy got rdy_seen=%b held=%b expected 0 1", sawRdy, held);
    end
    checkOp("abort_div_9/3", 1'b0, 1'b1, 32'd9, 32'd3);
  endtask

  task automatic test_both_ctrl;
    checkOp("both_ctrl_2x3", 1'b1, 1'b1, 32'd2, 32'd3);
  endtask

  task automatic test_back_to_back;
    checkOp("b2b_first", 1'b1, 1'b0, 32'h0000_1234, 32'hFFFF_FF00);
    checkOp("b2b_second", 1'b0, 1'b1, 32'hFFFF_F000, 32'd7);
  endtask

  task automatic test_reset_mid;
    int          lat;
    logic [31:0] res;
    logic        exc, held, sawRdy;
    runOp(1'b0, 1'b1, 32'd5, 32'd0, lat, res, exc, held);
    ctrlMULT = 1'b1;
    opA = 32'h0000_1234;
    opB = 32'h0000_0010;
    @(posedge clock); #1;
    ctrlMULT = 1'b0;
    repeat (20) @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    vectors++;
    if (result !== 32'd0 || exception !== 1'b0 || resultRDY !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs got res=%h exc=%b rdy=%b expected 0 0 0",
               result, exception, resultRDY);
    end
    @(negedge clock);
    reset = 1'b1;
    sawRdy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (resultRDY) sawRdy = 1'b1;
    end
    vectors++;
    if (sawRdy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_no_rdy got %b expected 0", sawRdy);
    end
    checkOp("after_reset_mult", 1'b1, 1'b0, 32'hFFFF_FFFD, 32'd11);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_abort();
    test_both_ctrl();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
